// File: rtl/fft_pkg.sv
// Shared width helpers and the convergent-round reference for the DIT butterfly.
package fft_pkg;

  localparam int BFLY_LATENCY = 6;

  function automatic int calc_w(input int iw, input int cw);
    return iw + cw + 3;
  endfunction

  function automatic int calc_pw(input int iw, input int cw);
    return iw + cw + 2;
  endfunction

  function automatic int calc_drop(input int iw, input int cw, input int ow, input int shift);
    return (cw - 2) + (iw + 1 - ow) + shift;
  endfunction

  // Round half to even, drop `drop` LSBs, then wrap to an ow-bit signed value.
  function automatic longint conv_round(input longint val, input int drop, input int ow);
    longint r;
    if (drop == 0) begin
      r = val;
    end else begin
      r = (val + ((64'sd1 <<< (drop - 1)) - 64'sd1) + ((val >>> drop) & 64'sd1)) >>> drop;
    end
    return (r <<< (64 - ow)) >>> (64 - ow);
  endfunction

endpackage

// File: rtl/dit_round.sv
// Registered convergent (round-half-to-even) rounding of one butterfly output component.
module dit_round #(
  parameter int IW   = 39,
  parameter int OW   = 17,
  parameter int DROP = 18
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic [IW-1:0] i_val,
  output logic [OW-1:0] o_val
);

  logic [IW-1:0] sum_s;
  logic [OW-1:0] val_d;
  logic [OW-1:0] val_q;
  logic          unused_s;

  generate
    if (DROP == 0) begin : g_no_drop
      assign sum_s = i_val;
    end else begin : g_round
      // Bias of half-minus-one plus the kept LSB carries exactly on ties only when that LSB is odd.
      localparam logic [IW-1:0] HALF_M1 = (IW'(1'b1) << (DROP - 1)) - IW'(1'b1);
      assign sum_s = i_val + HALF_M1 + IW'(i_val[DROP]);
    end
  endgenerate

  always_comb begin
    val_d = sum_s[DROP +: OW];
  end

  assign unused_s = ^sum_s;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      val_q <= '0;
    end else if (i_ce) begin
      val_q <= val_d;
    end
  end

  assign o_val = val_q;

endmodule

// File: rtl/hwbfly_dit.sv
// Six-stage radix-2 DIT butterfly: O1 = A + B*C, O2 = A - B*C using three real multiplies.
module hwbfly_dit
  import fft_pkg::*;
#(
  parameter int IWIDTH = 16,
  parameter int CWIDTH = 20,
  parameter int OWIDTH = 17,
  parameter int SHIFT  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ce,
  input  logic [2*CWIDTH-1:0]   i_coef,
  input  logic [2*IWIDTH-1:0]   i_left,
  input  logic [2*IWIDTH-1:0]   i_right,
  input  logic                  i_aux,
  output logic [2*OWIDTH-1:0]   o_left,
  output logic [2*OWIDTH-1:0]   o_right,
  output logic                  o_aux
);

  localparam int W    = calc_w(IWIDTH, CWIDTH);
  localparam int PW   = calc_pw(IWIDTH, CWIDTH);
  localparam int DROP = calc_drop(IWIDTH, CWIDTH, OWIDTH, SHIFT);
  localparam int BSW  = IWIDTH + 1;
  localparam int CSW  = CWIDTH + 1;
  localparam int LAT  = BFLY_LATENCY;

  // S1
  logic [2*IWIDTH-1:0]        a1_d, a1_q, b1_d, b1_q;
  logic [2*CWIDTH-1:0]        c1_d, c1_q;
  // S2
  logic [2*IWIDTH-1:0]        a2_d, a2_q;
  logic signed [IWIDTH-1:0]   br2_d, br2_q, bi2_d, bi2_q;
  logic signed [CWIDTH-1:0]   cr2_d, cr2_q, ci2_d, ci2_q;
  logic signed [BSW-1:0]      bs2_d, bs2_q;
  logic signed [CSW-1:0]      cs2_d, cs2_q;
  // S3
  logic [2*IWIDTH-1:0]        a3_d, a3_q;
  logic signed [PW-1:0]       p1_d, p1_q, p2_d, p2_q, p3_d, p3_q;
  // S4
  logic signed [W-1:0]        aalr4_d, aalr4_q, aali4_d, aali4_q;
  logic signed [W-1:0]        bcr4_d, bcr4_q, bci4_d, bci4_q;
  // S5
  logic signed [W-1:0]        o1r5_d, o1r5_q, o1i5_d, o1i5_q;
  logic signed [W-1:0]        o2r5_d, o2r5_q, o2i5_d, o2i5_q;
  // aux travels alongside every stage, including the rounding register
  logic [LAT-1:0]             aux_d, aux_q;

  logic [OWIDTH-1:0]          o1r_s, o1i_s, o2r_s, o2i_s;

  // Next-state datapath for S1..S5 and the aux delay line.
  always_comb begin
    a1_d  = i_left;
    b1_d  = i_right;
    c1_d  = i_coef;

    a2_d  = a1_q;
    br2_d = $signed(b1_q[2*IWIDTH-1:IWIDTH]);
    bi2_d = $signed(b1_q[IWIDTH-1:0]);
    cr2_d = $signed(c1_q[2*CWIDTH-1:CWIDTH]);
    ci2_d = $signed(c1_q[CWIDTH-1:0]);
    bs2_d = BSW'(br2_d) + BSW'(bi2_d);
    cs2_d = CSW'(cr2_d) + CSW'(ci2_d);

    a3_d  = a2_q;
    p1_d  = PW'(cr2_q) * PW'(br2_q);
    p2_d  = PW'(ci2_q) * PW'(bi2_q);
    p3_d  = PW'(cs2_q) * PW'(bs2_q);

    // (Cr+Ci)(Br+Bi) - CrBr - CiBi leaves the cross terms CrBi + CiBr.
    bcr4_d  = W'(p1_q) - W'(p2_q);
    bci4_d  = W'(p3_q) - W'(p1_q) - W'(p2_q);
    aalr4_d = W'($signed(a3_q[2*IWIDTH-1:IWIDTH])) <<< (CWIDTH - 2);
    aali4_d = W'($signed(a3_q[IWIDTH-1:0])) <<< (CWIDTH - 2);

    o1r5_d = aalr4_q + bcr4_q;
    o1i5_d = aali4_q + bci4_q;
    o2r5_d = aalr4_q - bcr4_q;
    o2i5_d = aali4_q - bci4_q;

    aux_d  = {aux_q[LAT-2:0], i_aux};
  end

  // Pipeline registers: synchronous clear beats clock enable.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      a1_q    <= '0;
      b1_q    <= '0;
      c1_q    <= '0;
      a2_q    <= '0;
      br2_q   <= '0;
      bi2_q   <= '0;
      cr2_q   <= '0;
      ci2_q   <= '0;
      bs2_q   <= '0;
      cs2_q   <= '0;
      a3_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      aalr4_q <= '0;
      aali4_q <= '0;
      bcr4_q  <= '0;
      bci4_q  <= '0;
      o1r5_q  <= '0;
      o1i5_q  <= '0;
      o2r5_q  <= '0;
      o2i5_q  <= '0;
      aux_q   <= '0;
    end else if (i_ce) begin
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      c1_q    <= c1_d;
      a2_q    <= a2_d;
      br2_q   <= br2_d;
      bi2_q   <= bi2_d;
      cr2_q   <= cr2_d;
      ci2_q   <= ci2_d;
      bs2_q   <= bs2_d;
      cs2_q   <= cs2_d;
      a3_q    <= a3_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      aalr4_q <= aalr4_d;
      aali4_q <= aali4_d;
      bcr4_q  <= bcr4_d;
      bci4_q  <= bci4_d;
      o1r5_q  <= o1r5_d;
      o1i5_q  <= o1i5_d;
      o2r5_q  <= o2r5_d;
      o2i5_q  <= o2i5_d;
      aux_q   <= aux_d;
    end
  end

  dit_round #(.IW(W), .OW(OWIDTH), .DROP(DROP)) u_round_o1r (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_val(o1r5_q), .o_val(o1r_s)
  );
  dit_round #(.IW(W), .OW(OWIDTH), .DROP(DROP)) u_round_o1i (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_val(o1i5_q), .o_val(o1i_s)
  );
  dit_round #(.IW(W), .OW(OWIDTH), .DROP(DROP)) u_round_o2r (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_val(o2r5_q), .o_val(o2r_s)
  );
  dit_round #(.IW(W), .OW(OWIDTH), .DROP(DROP)) u_round_o2i (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_val(o2i5_q), .o_val(o2i_s)
  );

  assign o_left  = {o1r_s, o1i_s};
  assign o_right = {o2r_s, o2i_s};
  assign o_aux   = aux_q[LAT-1];

endmodule

// File: tb/tb_hwbfly_dit.sv
// Self-checking bench for hwbfly_dit: complex-arithmetic reference model plus literal spot checks.
module tb_hwbfly_dit;
  import fft_pkg::*;

  localparam int IW   = 16;
  localparam int CW   = 20;
  localparam int OW   = 17;
  localparam int DROP = calc_drop(16, 20, 17, 0);
  localparam int LAT  = 6;
  localparam int UNITY = 262144;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ce;
  logic [2*CW-1:0] coef;
  logic [2*IW-1:0] left, right;
  logic            aux;
  logic [2*OW-1:0] o_left, o_right;
  logic            o_aux;

  int checks = 0;
  int errors = 0;

  hwbfly_dit dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_coef(coef),
    .i_left(left), .i_right(right), .i_aux(aux),
    .o_left(o_left), .o_right(o_right), .o_aux(o_aux)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint o1r, o1i, o2r, o2i;
    bit     aux;
  } exp_t;

  exp_t hist[$];
  bit   model_live = 1'b0;
  bit   last_hold  = 1'b0;
  bit   prev_valid = 1'b0;
  logic [2*OW-1:0] prev_l, prev_r;
  logic            prev_a;

  // Complex butterfly in plain integer arithmetic, then the package rounding rule.
  function automatic exp_t model(input logic [2*IW-1:0] l, input logic [2*IW-1:0] r,
                                 input logic [2*CW-1:0] c, input bit ax);
    exp_t   e;
    longint ar, ai, br, bi, cr, ci, bcr, bci, sc;
    ar  = longint'($signed(l[2*IW-1:IW]));
    ai  = longint'($signed(l[IW-1:0]));
    br  = longint'($signed(r[2*IW-1:IW]));
    bi  = longint'($signed(r[IW-1:0]));
    cr  = longint'($signed(c[2*CW-1:CW]));
    ci  = longint'($signed(c[CW-1:0]));
    bcr = cr * br - ci * bi;
    bci = cr * bi + ci * br;
    sc  = longint'(UNITY);
    e.o1r = conv_round(ar * sc + bcr, DROP, OW);
    e.o1i = conv_round(ai * sc + bci, DROP, OW);
    e.o2r = conv_round(ar * sc - bcr, DROP, OW);
    e.o2i = conv_round(ai * sc - bci, DROP, OW);
    e.aux = ax;
    return e;
  endfunction

  // Model: the k-th accepted sample since reset must appear after the (k+6)-th enabled edge.
  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      hist.delete();
      model_live = 1'b1;
      last_hold  = 1'b0;
    end else begin
      last_hold = (ce == 1'b0);
      if (ce) hist.push_back(model(left, right, coef, aux));
    end
  end

  // Compare DUT against the model every cycle, and check outputs freeze across stalls.
  always @(negedge clk) begin
    exp_t e;
    logic [2*OW-1:0] el, er;
    if (model_live) begin
      if (hist.size() >= LAT) begin
        e = hist[hist.size() - LAT];
      end else begin
        e.o1r = 0; e.o1i = 0; e.o2r = 0; e.o2i = 0; e.aux = 1'b0;
      end
      el = {OW'(e.o1r), OW'(e.o1i)};
      er = {OW'(e.o2r), OW'(e.o2i)};
      checks++;
      if (o_left !== el || o_right !== er || o_aux !== e.aux) begin
        errors++;
        $display("FAIL model @%0t: got L=%h R=%h aux=%b, expected L=%h R=%h aux=%b",
                 $time, o_left, o_right, o_aux, el, er, e.aux);
      end
      if (prev_valid && last_hold) begin
        checks++;
        if (o_left !== prev_l || o_right !== prev_r || o_aux !== prev_a) begin
          errors++;
          $display("FAIL stall_hold @%0t: got L=%h R=%h aux=%b, expected L=%h R=%h aux=%b",
                   $time, o_left, o_right, o_aux, prev_l, prev_r, prev_a);
        end
      end
      prev_l = o_left;
      prev_r = o_right;
      prev_a = o_aux;
      prev_valid = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int ar, input int ai, input int br, input int bi,
                        input int cr, input int ci, input bit ax);
    left  = {IW'(ar), IW'(ai)};
    right = {IW'(br), IW'(bi)};
    coef  = {CW'(cr), CW'(ci)};
    aux   = ax;
  endtask

  task automatic rand_in();
    int cr, ci;
    cr = int'($urandom_range(0, 1048574)) - 524287;
    ci = int'($urandom_range(0, 1048574)) - 524287;
    left  = $urandom;
    right = $urandom;
    coef  = {CW'(cr), CW'(ci)};
    aux   = 1'($urandom_range(0, 1));
  endtask

  task automatic check_lit(input string name, input int o1r, input int o1i,
                           input int o2r, input int o2i, input bit ax);
    logic [2*OW-1:0] el, er;
    el = {OW'(o1r), OW'(o1i)};
    er = {OW'(o2r), OW'(o2i)};
    checks++;
    if (o_left !== el || o_right !== er || o_aux !== ax) begin
      errors++;
      $display("FAIL %s: got L=%h R=%h aux=%b, expected L=%h R=%h aux=%b",
               name, o_left, o_right, o_aux, el, er, ax);
    end
  endtask

  // One sample with aux=1, flushed with zeros; literal result after 6 enabled edges, aux one cycle wide.
  task automatic directed(input string name, input int ar, input int ai, input int br, input int bi,
                          input int cr, input int ci,
                          input int o1r, input int o1i, input int o2r, input int o2i);
    ce = 1'b1;
    set_in(ar, ai, br, bi, cr, ci, 1'b1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    repeat (LAT - 1) tick();
    check_lit(name, o1r, o1i, o2r, o2i, 1'b1);
    tick();
    check_lit({name, "_after"}, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    int sent;
    rst_n = 1'b0;
    ce    = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    tick();
    tick();
    check_lit("reset_state", 0, 0, 0, 0, 1'b0);
    rst_n = 1'b1;

    directed("unity",      100, -50, 30, 20, UNITY, 0,       130, -30,  70, -70);
    directed("minus_j",    100, -50, 30, 20, 0, -UNITY,      120, -80,  80, -20);
    directed("half_even",  0, 0, 3, 1, 131072, 0,            2, 0, -2, 0);
    directed("extreme_neg", -32768, -32768, -32768, -32768, UNITY, 0, -65536, -65536, 0, 0);
    directed("extreme_pos", 32767, 32767, 32767, 32767, UNITY, 0, 65534, 65534, 0, 0);

    // Random stream with ~50% clock enable; garbage inputs on stalled cycles must be ignored.
    sent = 0;
    while (sent < 20) begin
      ce = 1'($urandom_range(0, 1));
      rand_in();
      if (ce) sent++;
      tick();
    end
    ce = 1'b0;
    repeat (5) tick();
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    repeat (12) begin
      ce = 1'($urandom_range(0, 1));
      tick();
    end
    ce = 1'b1;
    repeat (LAT + 2) tick();

    // Mid-stream reset with four samples in flight.
    ce = 1'b1;
    repeat (4) begin
      rand_in();
      tick();
    end
    rst_n = 1'b0;
    rand_in();
    tick();
    check_lit("mid_reset", 0, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    directed("post_reset", 100, -50, 30, 20, UNITY, 0, 130, -30, 70, -70);

    ce = 1'b1;
    repeat (40) begin
      rand_in();
      ce = 1'($urandom_range(0, 1));
      tick();
    end
    ce = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    repeat (LAT + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
